// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, flush, freeze and forwarding control for the 5-stage pipe
//
// Purpose: sequences the IF/ID, ID/EX and EX/MEM pipeline registers.
//   Load-use hazards bubble ID/EX while holding PC and IF/ID.
//   Taken branches resolved in MEM flush the younger stages.
//   A busy data memory freezes the whole pipe.
//   Also drives the EX-stage forwarding selects and keeps saturating stall/flush counters.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_order, ex_order              instruction words in ID and EX
//   ex_MemRead                      EX instruction is a load
//   mem_RegWrite, mem_write_reg     MEM-stage register write and its destination
//   wb_RegWrite, wb_write_reg       WB-stage register write and its destination
//   mem_branch_taken, mem_wait      branch resolved taken in MEM / data memory busy
//   pc_write, ifid_write, idex_write  register load enables
//   idex_bubble                     ID/EX loads NOP controls
//   ifid_flush, idex_flush, exmem_flush  register clears
//   fwd_a, fwd_b                    ALU operand selects: 00 regfile, 10 MEM, 01 WB
//   stall_cycles, flush_events      saturating event counters
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_order,
    input  logic [31:0]      ex_order,
    input  logic             ex_MemRead,
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_write_reg,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_write_reg,
    input  logic             mem_branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT       = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t state, state_next;

    logic [5:0] id_op;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex;
    logic       id_reads_rt;
    logic       load_use;
    logic       br_pending;
    logic       flush_now;
    logic       flush_cycle;
    logic       unused_bits;

    assign id_op = id_order[31:26];
    assign rs_id = id_order[25:21];
    assign rt_id = id_order[20:16];
    assign rs_ex = ex_order[25:21];
    assign rt_ex = ex_order[20:16];
    assign unused_bits = ^{id_order[15:0], ex_order[31:26], ex_order[15:0]};

    // R-type, sw and beq read rt as a source; other opcodes use rt as a destination.
    assign id_reads_rt = (id_op == 6'h00) || (id_op == 6'h2b) || (id_op == 6'h04);

    assign load_use = ex_MemRead && (rt_ex != 5'd0) &&
                      ((rt_ex == rs_id) || (id_reads_rt && (rt_ex == rt_id)));

    // A branch that arrived while memory was busy is remembered by the FLUSH_PEND state.
    assign br_pending  = (state == FLUSH_PEND);
    assign flush_now   = mem_branch_taken || br_pending;
    assign flush_cycle = !rst && !mem_wait && flush_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = RUN;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_next = flush_now ? FLUSH_PEND : WAIT;
        end else if (flush_now) begin
            // PC loads the branch target; the younger stages are cleared.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            // Single-cycle stall: next cycle the load has moved on and ex_MemRead drops.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_RegWrite && (mem_write_reg != 5'd0) && (mem_write_reg == src)) begin
            return 2'b10;
        end else if (wb_RegWrite && (wb_write_reg != 5'd0) && (wb_write_reg == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            fwd_a = fwd_sel(rs_ex);
            fwd_b = fwd_sel(rt_ex);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (flush_cycle && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_order, ex_order;
    logic        ex_MemRead, mem_RegWrite, wb_RegWrite;
    logic [4:0]  mem_write_reg, wb_write_reg;
    logic        mem_branch_taken, mem_wait;

    logic        pc_write, ifid_write, idex_write, idex_bubble;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_events;

    logic        pc_write4, ifid_write4, idex_write4, idex_bubble4;
    logic        ifid_flush4, idex_flush4, exmem_flush4;
    logic [1:0]  fwd_a4, fwd_b4;
    logic [3:0]  stall_cycles4, flush_events4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_order(id_order), .ex_order(ex_order),
        .ex_MemRead(ex_MemRead), .mem_RegWrite(mem_RegWrite), .mem_write_reg(mem_write_reg),
        .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg),
        .mem_branch_taken(mem_branch_taken), .mem_wait(mem_wait),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_order(id_order), .ex_order(ex_order),
        .ex_MemRead(ex_MemRead), .mem_RegWrite(mem_RegWrite), .mem_write_reg(mem_write_reg),
        .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg),
        .mem_branch_taken(mem_branch_taken), .mem_wait(mem_wait),
        .pc_write(pc_write4), .ifid_write(ifid_write4), .idex_write(idex_write4),
        .idex_bubble(idex_bubble4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .exmem_flush(exmem_flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .stall_cycles(stall_cycles4), .flush_events(flush_events4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic idle_inputs();
        id_order         = 32'h0;
        ex_order         = 32'h0;
        ex_MemRead       = 1'b0;
        mem_RegWrite     = 1'b0;
        mem_write_reg    = 5'd0;
        wb_RegWrite      = 1'b0;
        wb_write_reg     = 5'd0;
        mem_branch_taken = 1'b0;
        mem_wait         = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset: outputs forced while rst=1, forwarding held at 00
        tick();
        mem_RegWrite  = 1'b1;
        mem_write_reg = 5'd5;
        ex_order      = instr(6'h00, 5'd5, 5'd5);
        settle();
        check_eq("rst_pc_write", pc_write, 1'b0);
        check_eq("rst_ifid_write", ifid_write, 1'b0);
        check_eq("rst_idex_write", idex_write, 1'b0);
        check_eq("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        check_eq("rst_bubble", idex_bubble, 1'b1);
        check_eq("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        tick();
        check_eq("rst_stall_cnt", stall_cycles, 16'd0);
        check_eq("rst_flush_cnt", flush_events, 16'd0);

        rst = 1'b0;
        idle_inputs();
        settle();
        check_eq("run_enables", {pc_write, ifid_write, idex_write}, 3'b111);
        check_eq("run_flush_bubble", {ifid_flush, idex_flush, exmem_flush, idex_bubble}, 4'b0000);
        tick();
        check_eq("run_stall_cnt", stall_cycles, 16'd0);

        // Load-use via ID rs: lw $8 in EX, add $9,$8,$3 in ID
        ex_order   = instr(6'h23, 5'd2, 5'd8);
        ex_MemRead = 1'b1;
        id_order   = instr(6'h00, 5'd8, 5'd3);
        settle();
        check_eq("lu_enables", {pc_write, ifid_write, idex_write}, 3'b001);
        check_eq("lu_bubble", idex_bubble, 1'b1);
        check_eq("lu_no_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b000);
        tick();
        check_eq("lu_stall_cnt", stall_cycles, 16'd1);
        ex_order   = instr(6'h00, 5'd8, 5'd3);
        ex_MemRead = 1'b0;
        id_order   = instr(6'h00, 5'd1, 5'd2);
        settle();
        check_eq("lu_release", {pc_write, idex_bubble}, 2'b10);
        tick();
        check_eq("lu_stall_once", stall_cycles, 16'd1);

        // Load-use via ID rt for sw; lw in ID writes rt so it must not stall
        ex_order   = instr(6'h23, 5'd2, 5'd8);
        ex_MemRead = 1'b1;
        id_order   = instr(6'h2b, 5'd1, 5'd8);
        settle();
        check_eq("lu_sw_rt", {pc_write, idex_bubble}, 2'b01);
        tick();
        check_eq("lu_sw_cnt", stall_cycles, 16'd2);
        id_order = instr(6'h23, 5'd1, 5'd8);
        settle();
        check_eq("lu_lw_rt_nostall", {pc_write, idex_bubble}, 2'b10);
        tick();

        // Register $0 never creates a hazard nor a forward
        ex_order      = instr(6'h23, 5'd0, 5'd0);
        ex_MemRead    = 1'b1;
        id_order      = instr(6'h00, 5'd0, 5'd0);
        mem_RegWrite  = 1'b1;
        mem_write_reg = 5'd0;
        settle();
        check_eq("zero_nostall", {pc_write, idex_bubble}, 2'b10);
        check_eq("zero_fwd_a", fwd_a, 2'b00);
        tick();
        check_eq("zero_stall_cnt", stall_cycles, 16'd2);

        // Forwarding priority: MEM beats WB
        idle_inputs();
        ex_order      = instr(6'h00, 5'd5, 5'd6);
        mem_RegWrite  = 1'b1;
        mem_write_reg = 5'd5;
        wb_RegWrite   = 1'b1;
        wb_write_reg  = 5'd5;
        settle();
        check_eq("fwd_mem_prio", {fwd_a, fwd_b}, 4'b1000);
        mem_RegWrite = 1'b0;
        settle();
        check_eq("fwd_wb", {fwd_a, fwd_b}, 4'b0100);
        mem_RegWrite  = 1'b1;
        mem_write_reg = 5'd6;
        settle();
        check_eq("fwd_b_mem", {fwd_a, fwd_b}, 4'b0110);
        tick();

        // Branch during a 3-cycle memory wait
        idle_inputs();
        mem_wait         = 1'b1;
        mem_branch_taken = 1'b1;
        settle();
        check_eq("wait_br_freeze", {pc_write, ifid_write, idex_write}, 3'b000);
        check_eq("wait_br_noflush", {ifid_flush, idex_flush, exmem_flush, idex_bubble}, 4'b0000);
        tick();
        mem_branch_taken = 1'b0;
        settle();
        check_eq("wait2_freeze", {pc_write, ifid_flush}, 2'b00);
        tick();
        settle();
        check_eq("wait3_freeze", {pc_write, ifid_flush}, 2'b00);
        tick();
        check_eq("wait_stall_cnt", stall_cycles, 16'd5);
        mem_wait = 1'b0;
        settle();
        check_eq("pend_flush", {ifid_flush, idex_flush, exmem_flush, pc_write}, 4'b1111);
        tick();
        check_eq("pend_flush_cnt", flush_events, 16'd1);
        check_eq("pend_stall_cnt", stall_cycles, 16'd5);
        settle();
        check_eq("pend_done", {ifid_flush, pc_write}, 2'b01);
        tick();

        // Branch together with load-use: flush wins, no bubble
        ex_order         = instr(6'h23, 5'd2, 5'd8);
        ex_MemRead       = 1'b1;
        id_order         = instr(6'h00, 5'd8, 5'd3);
        mem_branch_taken = 1'b1;
        settle();
        check_eq("br_lu_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        check_eq("br_lu_nobubble", {pc_write, idex_bubble}, 2'b10);
        tick();
        check_eq("br_lu_flush_cnt", flush_events, 16'd2);
        check_eq("br_lu_stall_cnt", stall_cycles, 16'd5);

        // Reset during FLUSH_PEND discards the pending flush
        idle_inputs();
        mem_wait         = 1'b1;
        mem_branch_taken = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_eq("rst_pend_discard", {ifid_flush, idex_flush, exmem_flush, pc_write}, 4'b0001);
        check_eq("rst_pend_cnts", {stall_cycles, flush_events}, 32'd0);
        tick();

        // Saturation: 20 frozen cycles, 4-bit counter stops at 15
        mem_wait = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check_eq("sat_cnt4_14", stall_cycles4, 4'd14);
        for (int i = 0; i < 6; i++) tick();
        check_eq("sat_cnt4_hold", stall_cycles4, 4'd15);
        check_eq("sat_cnt16", stall_cycles, 16'd20);
        mem_wait = 1'b0;
        settle();
        check_eq("wait_exit_run", {pc_write, ifid_write, idex_write, ifid_flush}, 4'b1110);
        tick();
        check_eq("sat_cnt4_final", stall_cycles4, 4'd15);
        check_eq("sat_flush4", flush_events4, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
